// File: rtl/sound_pkg.sv
// Shared encodings and default timing constants for the game sound sequencer.
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_WALL = 2'b01,
    SRC_HIT  = 2'b10,
    SRC_GOAL = 2'b11
  } src_e;

  // 50 MHz clock: 1 ms ticks, 880/440/220 Hz tones
  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_GOAL_HALF = 28409;
  localparam int DEF_HIT_HALF  = 56818;
  localparam int DEF_WALL_HALF = 113636;
  localparam int DEF_GOAL_LEN  = 400;
  localparam int DEF_HIT_LEN   = 60;
  localparam int DEF_WALL_LEN  = 30;
  localparam int DEF_GAP_LEN   = 20;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: phase starts high on start, toggles every `half` cycles while enabled.
module tone_gen
  import sound_pkg::*;
#(
  parameter int HW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [HW-1:0] half,
  output logic          wave
);

  logic [HW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (start) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en) begin
      if (cnt_q >= half - 1'b1) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign wave = phase_q;

endmodule

// File: rtl/sound_sequencer.sv
// Latches hit/wall/goal pulses, arbitrates goal > hit > wall, and plays one tone burst
// at a time followed by a silent gap; goal preempts a running hit/wall burst.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int GOAL_HALF = DEF_GOAL_HALF,
  parameter int HIT_HALF  = DEF_HIT_HALF,
  parameter int WALL_HALF = DEF_WALL_HALF,
  parameter int GOAL_LEN  = DEF_GOAL_LEN,
  parameter int HIT_LEN   = DEF_HIT_LEN,
  parameter int WALL_LEN  = DEF_WALL_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [1:0] active_src
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(max2(max2(GOAL_LEN, HIT_LEN), max2(WALL_LEN, GAP_LEN)) + 1);
  localparam int HW = $clog2(max2(max2(GOAL_HALF, HIT_HALF), WALL_HALF) + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] GOAL_LAST = DW'(GOAL_LEN - 1);
  localparam logic [DW-1:0] HIT_LAST  = DW'(HIT_LEN - 1);
  localparam logic [DW-1:0] WALL_LAST = DW'(WALL_LEN - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_LEN - 1);
  localparam logic [HW-1:0] GOAL_HV   = HW'(GOAL_HALF);
  localparam logic [HW-1:0] HIT_HV    = HW'(HIT_HALF);
  localparam logic [HW-1:0] WALL_HV   = HW'(WALL_HALF);

  state_e        state_q, state_d;
  src_e          src_q, src_d;
  logic          pend_g_q, pend_g_d;
  logic          pend_h_q, pend_h_d;
  logic          pend_w_q, pend_w_d;
  logic          busy_q, busy_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] dur_q, dur_d;

  logic          tick_wrap;
  logic [DW-1:0] len_last;
  logic          tone_start;
  logic          tone_en;
  logic [HW-1:0] half_sel;
  logic          tone_wave;

  always_comb begin
    tick_wrap = (tick_q >= TICK_LAST);
    case (src_q)
      SRC_GOAL: len_last = GOAL_LAST;
      SRC_HIT:  len_last = HIT_LAST;
      default:  len_last = WALL_LAST;
    endcase

    state_d    = state_q;
    src_d      = src_q;
    pend_g_d   = pend_g_q | goal;
    pend_h_d   = pend_h_q | hit;
    pend_w_d   = pend_w_q | wall;
    tick_d     = tick_q;
    dur_d      = dur_q;
    tone_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        dur_d  = '0;
        // The granted flag clears, but a pulse in this same cycle re-arms it.
        if (pend_g_q) begin
          state_d    = ST_PLAY;
          src_d      = SRC_GOAL;
          pend_g_d   = goal;
          tone_start = 1'b1;
        end else if (pend_h_q) begin
          state_d    = ST_PLAY;
          src_d      = SRC_HIT;
          pend_h_d   = hit;
          tone_start = 1'b1;
        end else if (pend_w_q) begin
          state_d    = ST_PLAY;
          src_d      = SRC_WALL;
          pend_w_d   = wall;
          tone_start = 1'b1;
        end
      end
      ST_PLAY: begin
        // Goal aborts hit/wall with no gap; the aborted and lower requests are dropped.
        if (goal && (src_q != SRC_GOAL)) begin
          src_d      = SRC_GOAL;
          tick_d     = '0;
          dur_d      = '0;
          pend_g_d   = 1'b0;
          pend_h_d   = 1'b0;
          pend_w_d   = 1'b0;
          tone_start = 1'b1;
        end else if (tick_wrap) begin
          tick_d = '0;
          if (dur_q >= len_last) begin
            state_d = ST_GAP;
            src_d   = SRC_NONE;
            dur_d   = '0;
          end else begin
            dur_d = dur_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (tick_wrap) begin
          tick_d = '0;
          if (dur_q >= GAP_LAST) begin
            state_d = ST_IDLE;
            dur_d   = '0;
          end else begin
            dur_d = dur_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
        tick_d  = '0;
        dur_d   = '0;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    tone_en = (state_d == ST_PLAY);
    case (src_d)
      SRC_GOAL: half_sel = GOAL_HV;
      SRC_HIT:  half_sel = HIT_HV;
      default:  half_sel = WALL_HV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_NONE;
      pend_g_q <= 1'b0;
      pend_h_q <= 1'b0;
      pend_w_q <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= '0;
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      pend_g_q <= pend_g_d;
      pend_h_q <= pend_h_d;
      pend_w_q <= pend_w_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      dur_q    <= dur_d;
    end
  end

  tone_gen #(
    .HW(HW)
  ) u_tone (
    .clk   (clk),
    .rst   (rst),
    .en    (tone_en),
    .start (tone_start),
    .half  (half_sel),
    .wave  (tone_wave)
  );

  assign sound      = tone_wave & ~mute;
  assign busy       = busy_q;
  assign active_src = src_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with small timing parameters; outputs packed as {busy, active_src, sound}.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit = 1'b0;
  logic       wall = 1'b0;
  logic       goal = 1'b0;
  logic       mute = 1'b0;
  logic       sound;
  logic       busy;
  logic [1:0] active_src;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] GAP_V  = 4'b1000;
  localparam logic [3:0] IDLE_V = 4'b0000;

  sound_sequencer #(
    .TICK_DIV  (4),
    .GOAL_HALF (1),
    .HIT_HALF  (2),
    .WALL_HALF (3),
    .GOAL_LEN  (3),
    .HIT_LEN   (2),
    .WALL_LEN  (2),
    .GAP_LEN   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hit        (hit),
    .wall       (wall),
    .goal       (goal),
    .mute       (mute),
    .sound      (sound),
    .busy       (busy),
    .active_src (active_src)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, src, sound} for cycle i of a burst (cycle 0 is the first cycle after grant).
  function automatic logic [3:0] play_exp(input logic [1:0] src, input int half, input int i,
                                          input logic muted);
    logic ph;
    ph = (((i / half) % 2) == 0);
    return {1'b1, src, ph & ~muted};
  endfunction

  function automatic logic [3:0] obs();
    return {busy, active_src, sound};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (sound !== 1'b0) begin bad++; $display("FAIL reset_sound got=%b exp=0", sound); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (active_src !== 2'b00) begin bad++; $display("FAIL reset_src got=%b exp=00", active_src); end
    rst = 1'b0;
    step();
    total++;
    if (obs() !== IDLE_V) begin bad++; $display("FAIL reset_idle got=%b exp=%b", obs(), IDLE_V); end
  endtask

  task automatic test_single_hit();
    logic [3:0] e;
    hit = 1'b1;
    step();
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      e = play_exp(2'b10, 2, i, 1'b0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL single_hit_play cyc=%0d got=%b exp=%b", i, obs(), e); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs() !== GAP_V) begin bad++; $display("FAIL single_hit_gap cyc=%0d got=%b exp=%b", i, obs(), GAP_V); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs() !== IDLE_V) begin bad++; $display("FAIL single_hit_idle cyc=%0d got=%b exp=%b", i, obs(), IDLE_V); end
    end
  endtask

  task automatic test_priority();
    logic [1:0] srcs [3];
    int         halves [3];
    int         lens [3];
    logic [3:0] e;
    srcs   = '{2'b11, 2'b10, 2'b01};
    halves = '{1, 2, 3};
    lens   = '{12, 8, 8};
    hit = 1'b1; wall = 1'b1; goal = 1'b1;
    step();
    hit = 1'b0; wall = 1'b0; goal = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < lens[b]; i++) begin
        step();
        e = play_exp(srcs[b], halves[b], i, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL prio_play b=%0d cyc=%0d got=%b exp=%b", b, i, obs(), e); end
      end
      for (int i = 0; i < 4; i++) begin
        step();
        total++;
        if (obs() !== GAP_V) begin bad++; $display("FAIL prio_gap b=%0d cyc=%0d got=%b exp=%b", b, i, obs(), GAP_V); end
      end
      step();
      total++;
      if (obs() !== IDLE_V) begin bad++; $display("FAIL prio_idle b=%0d got=%b exp=%b", b, obs(), IDLE_V); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs() !== IDLE_V) begin bad++; $display("FAIL prio_tail cyc=%0d got=%b exp=%b", i, obs(), IDLE_V); end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] e;
    wall = 1'b1;
    step();
    wall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = play_exp(2'b01, 3, i, 1'b0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL preempt_wall cyc=%0d got=%b exp=%b", i, obs(), e); end
    end
    goal = 1'b1; hit = 1'b1;
    step();
    goal = 1'b0; hit = 1'b0;
    e = play_exp(2'b11, 1, 0, 1'b0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL preempt_switch got=%b exp=%b", obs(), e); end
    for (int i = 1; i < 12; i++) begin
      step();
      e = play_exp(2'b11, 1, i, 1'b0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL preempt_goal cyc=%0d got=%b exp=%b", i, obs(), e); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs() !== GAP_V) begin bad++; $display("FAIL preempt_gap cyc=%0d got=%b exp=%b", i, obs(), GAP_V); end
    end
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (obs() !== IDLE_V) begin bad++; $display("FAIL preempt_no_hit cyc=%0d got=%b exp=%b", i, obs(), IDLE_V); end
    end
  endtask

  task automatic test_coalesce();
    logic [3:0] e;
    hit = 1'b1;
    step();
    hit = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (b == 0 && (i == 1 || i == 3 || i == 5)) hit = 1'b1;
        step();
        hit = 1'b0;
        e = play_exp(2'b10, 2, i, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL coalesce_play b=%0d cyc=%0d got=%b exp=%b", b, i, obs(), e); end
      end
      for (int i = 0; i < 4; i++) begin
        step();
        total++;
        if (obs() !== GAP_V) begin bad++; $display("FAIL coalesce_gap b=%0d cyc=%0d got=%b exp=%b", b, i, obs(), GAP_V); end
      end
      step();
      total++;
      if (obs() !== IDLE_V) begin bad++; $display("FAIL coalesce_idle b=%0d got=%b exp=%b", b, obs(), IDLE_V); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs() !== IDLE_V) begin bad++; $display("FAIL coalesce_tail cyc=%0d got=%b exp=%b", i, obs(), IDLE_V); end
    end
  endtask

  task automatic test_mute();
    logic [3:0] e;
    mute = 1'b1;
    goal = 1'b1;
    step();
    goal = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      e = play_exp(2'b11, 1, i, 1'b1);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL mute_play cyc=%0d got=%b exp=%b", i, obs(), e); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs() !== GAP_V) begin bad++; $display("FAIL mute_gap cyc=%0d got=%b exp=%b", i, obs(), GAP_V); end
    end
    step();
    total++;
    if (obs() !== IDLE_V) begin bad++; $display("FAIL mute_idle got=%b exp=%b", obs(), IDLE_V); end
    mute = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] e;
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    wall = 1'b1;
    step();
    wall = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (sound !== 1'b0) begin bad++; $display("FAIL arst_sound got=%b exp=0", sound); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++;
    if (active_src !== 2'b00) begin bad++; $display("FAIL arst_src got=%b exp=00", active_src); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs() !== IDLE_V) begin bad++; $display("FAIL arst_lost cyc=%0d got=%b exp=%b", i, obs(), IDLE_V); end
    end
    hit = 1'b1;
    step();
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      e = play_exp(2'b10, 2, i, 1'b0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL arst_replay cyc=%0d got=%b exp=%b", i, obs(), e); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs() !== GAP_V) begin bad++; $display("FAIL arst_gap cyc=%0d got=%b exp=%b", i, obs(), GAP_V); end
    end
    step();
    total++;
    if (obs() !== IDLE_V) begin bad++; $display("FAIL arst_idle got=%b exp=%b", obs(), IDLE_V); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_priority();
    test_preempt();
    test_coalesce();
    test_mute();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Schedules the single speaker output among three game-event requesters: goal, hit (paddle) and wall.
- Latches one-cycle event pulses from the game controller and arbitrates them by priority.
- Plays one tone burst at a time, with a per-source pitch and duration, separated by a silent gap.
- Sits between game_controller (hit/wall/goal) and the board sound pin; replaces direct tone generation downstream.

Parameters:
- TICK_DIV, 50000: clk cycles per duration tick (1 ms at 50 MHz); legal range >=2.
- GOAL_HALF, 28409: half-period of goal tone in clk cycles (880 Hz); legal range >=1.
- HIT_HALF, 56818: half-period of hit tone in clk cycles (440 Hz); legal range >=1.
- WALL_HALF, 113636: half-period of wall tone in clk cycles (220 Hz); legal range >=1.
- GOAL_LEN, 400: goal burst length in ticks; legal range >=1.
- HIT_LEN, 60: hit burst length in ticks; legal range >=1.
- WALL_LEN, 30: wall burst length in ticks; legal range >=1.
- GAP_LEN, 20: silent ticks after every burst; legal range >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- hit  in  1  one-cycle pulse: ball hit a paddle
- wall  in  1  one-cycle pulse: ball hit top/bottom wall
- goal  in  1  one-cycle pulse: point scored
- mute  in  1  level; 1 forces sound low, sequencing continues
- sound  out  1  square-wave speaker drive
- busy  out  1  high in PLAY or GAP
- active_src  out  2  00 none, 01 wall, 10 hit, 11 goal (valid in PLAY; 00 otherwise)

Behaviour:
- Reset (async, any state, mid-burst included) clears all state: sound=0, busy=0, active_src=00, pending flags 0, all counters 0, state IDLE.
- Pending flags pend_g, pend_h, pend_w:
  - Each flag is set at the edge that samples its input high.
  - Repeat pulses while a flag is already set coalesce into that one request.
  - A flag is cleared only when its source is granted or preempted (below); a pulse arriving the same cycle its flag clears re-sets the flag.
- States: IDLE, PLAY, GAP.
- IDLE: if any pending flag is set, grant the highest-priority one (goal > hit > wall) and go to PLAY at the next edge. At that edge:
  - the granted flag clears;
  - active_src = granted source; busy=1; tone phase starts high;
  - half-period counter, tick prescaler and duration counter all load 0.
- Latency: a pulse sampled at edge k (from IDLE, nothing pending) gives busy=1 and sound=1 (unmuted) after edge k+1.
- PLAY:
  - The tone phase toggles every <SRC>_HALF clk cycles.
  - sound = phase AND NOT mute.
  - The tick prescaler wraps every TICK_DIV cycles and increments the duration counter on each wrap.
  - When the duration counter reaches <SRC>_LEN (exactly LEN*TICK_DIV cycles after grant), go to GAP: sound=0, active_src=00, prescaler and counter reloaded.
- GAP: sound=0 and busy=1 for exactly GAP_LEN*TICK_DIV cycles, then IDLE. IDLE may grant again at the following edge, so there is exactly one IDLE cycle between bursts.
- Preemption: a goal pulse sampled while PLAY is serving hit or wall:
  - aborts that burst at the next edge and enters PLAY(goal) directly, with no gap;
  - clears pend_h and pend_w;
  - the aborted source is not replayed.
- A goal pulse during PLAY(goal) or during GAP only sets pend_g.
- Simultaneous pulses in one cycle: all flags set; served in priority order, each burst followed by a gap.
- Arithmetic and widths:
  - Counter widths are $clog2 of (max parameter + 1).
  - Comparisons use >= so a counter can never overrun.
  - No arithmetic overflow is possible for legal parameter values.
- The mute level does not affect the state, counters or busy.

Decomposition:
- Shared package sound_pkg holds:
  - the state encoding (IDLE/PLAY/GAP);
  - the active_src codes (SRC_NONE/WALL/HIT/GOAL);
  - the default frequency and duration constants.
- One sub-module, tone_gen:
  - enable plus a half-period input, square-wave output;
  - phase reset on enable rising.
- Arbitration, tick prescaler and FSM stay in sound_sequencer.

Test Plan:
Bench parameters: TICK_DIV=4, GOAL_HALF=1, HIT_HALF=2, WALL_HALF=3, GOAL_LEN=3, HIT_LEN=2, WALL_LEN=2, GAP_LEN=1.
- Single hit pulse at edge k -> busy=1, active_src=10 after edge k+1; sound toggles every 2 cycles for 8 cycles; then 4 cycles busy=1 with sound=0; busy=0 after that.
- hit, wall and goal pulsed in the same cycle -> bursts in order goal (12 cycles, toggle every cycle), gap 4, IDLE 1 cycle, hit (8 cycles), gap 4, IDLE 1 cycle, wall (8 cycles), gap 4; then idle.
- Wall burst in progress, goal pulse plus an extra hit pulse 3 cycles into the burst -> active_src=11 at the next edge with no gap; pend_h cleared, so no hit burst follows the goal burst.
- Three hit pulses during a single hit burst -> exactly one additional hit burst after the gap.
- mute=1 throughout a goal burst -> sound stays 0; busy and active_src timing identical to the unmuted case.
- rst asserted mid-PLAY between clock edges -> sound, busy and active_src drop to 0 immediately; pending requests are lost; a hit pulse after reset release plays normally.
